// File: rtl/bound_flasher_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bf_pkg
// Brief    : State codes and lamp-level bounds for the bound-flasher sequencer
// Revision : 1.0
// ============================================================================
package bf_pkg;

    localparam int LAMP_N = 16;

    localparam logic [4:0] LVL_MAX  = 5'd16;
    localparam logic [4:0] LVL_MID  = 5'd10;
    localparam logic [4:0] LVL_KICK = 5'd5;
    localparam logic [4:0] LVL_MIN  = 5'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP16    = 3'd1,
        ST_DN5     = 3'd2,
        ST_UP10    = 3'd3,
        ST_DN0     = 3'd4,
        ST_UP5     = 3'd5,
        ST_DNEND   = 3'd6,
        ST_ILLEGAL = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bound_flasher_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : bound_flasher_sequencer_if
// Brief    : Request input and lamp/status outputs of the flasher sequencer
// Revision : 1.0
// ============================================================================
interface bound_flasher_sequencer_if;
    import bf_pkg::*;

    logic                flick;
    logic [LAMP_N-1:0]   lamps;
    logic [4:0]          level;
    state_t              state;
    logic                busy;
    logic                done;

    modport master (
        output flick,
        input  lamps, level, state, busy, done
    );

    modport slave (
        input  flick,
        output lamps, level, state, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/bf_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : bf_tick_prescaler
// Brief    : Divides the clock into one-cycle lamp step strobes while running
// Revision : 1.0
// ============================================================================
module bf_tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic run,
    output logic      tick
);

    localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = run && (r_cnt == C_LAST);

    // Held at zero while idle so every pattern starts a full period from entry.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bound_flasher_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bound_flasher_sequencer
// Brief    : Bounded lamp-bar flash pattern with kickback rewind on flick
// Revision : 1.0
// ============================================================================
module bound_flasher_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int LAMP_N   = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    bound_flasher_sequencer_if.slave   bus
);
    import bf_pkg::*;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [4:0]          r_level;
    logic [4:0]          w_level_nxt;
    logic [4:0]          w_up;
    logic [4:0]          w_dn;
    logic [LAMP_N-1:0]   r_lamps;
    logic [LAMP_N-1:0]   w_lamps_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_wrap;
    logic                w_run;
    logic                w_tick;

    assign w_run = (r_state != ST_IDLE);
    assign w_up  = r_level + 5'd1;
    assign w_dn  = r_level - 5'd1;

    bf_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_level <= LVL_MIN;
            r_lamps <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_lamps <= w_lamps_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // The bound is checked against the post-step level so the state change
    // lands on the same edge the bound is reached.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_done_nxt  = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_level_nxt = LVL_MIN;
                if (bus.flick) w_state_nxt = ST_UP16;
            end
            ST_UP16: if (w_tick) begin
                w_wrap      = (r_level >= LVL_MAX);
                w_level_nxt = w_up;
                if (w_up == LVL_MAX) w_state_nxt = ST_DN5;
            end
            ST_DN5: if (w_tick) begin
                w_wrap      = (r_level == LVL_MIN);
                w_level_nxt = w_dn;
                if (w_dn == LVL_KICK) w_state_nxt = bus.flick ? ST_UP16 : ST_UP10;
            end
            ST_UP10: if (w_tick) begin
                w_wrap      = (r_level >= LVL_MAX);
                w_level_nxt = w_up;
                if (w_up == LVL_MID) w_state_nxt = ST_DN0;
            end
            ST_DN0: if (w_tick) begin
                w_wrap      = (r_level == LVL_MIN);
                w_level_nxt = w_dn;
                if (w_dn == LVL_MIN) begin
                    w_state_nxt = bus.flick ? ST_UP10 : ST_UP5;
                end else if ((w_dn == LVL_KICK) && bus.flick) begin
                    w_state_nxt = ST_UP10;
                end
            end
            ST_UP5: if (w_tick) begin
                w_wrap      = (r_level >= LVL_MAX);
                w_level_nxt = w_up;
                if (w_up == LVL_KICK) w_state_nxt = ST_DNEND;
            end
            ST_DNEND: if (w_tick) begin
                w_wrap      = (r_level == LVL_MIN);
                w_level_nxt = w_dn;
                if (w_dn == LVL_MIN) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_level_nxt = LVL_MIN;
            end
        endcase
    end

    for (genvar i = 0; i < LAMP_N; i++) begin : g_lamp
        assign w_lamps_nxt[i] = (w_level_nxt > 5'(i));
    end

    assert property (@(posedge clk) disable iff (rst) !w_wrap);

    assign bus.lamps = r_lamps;
    assign bus.level = r_level;
    assign bus.state = r_state;
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: doc/bound_flasher_sequencer.md
# bound_flasher_sequencer

Bounded lamp-bar sequencer for the bound-flasher design. It owns the state register, the lamp-level up/down counter, the step prescaler and the 16-lamp output register. A `flick` request launches one full flash pattern. `flick` is sampled again at two kickback points, where it rewinds the pattern. The block sits between the debounced `flick` input and the lamp drivers.

## Interface
- `TICK_DIV`, default 4: clock cycles per lamp step; legal range ≥ 1.
- `LAMP_N`, default 16: lamp count; fixed at 16 for this release.

Ports:
- `clk` — input, 1 — system clock; all logic is on the rising edge.
- `rst` — input, 1 — reset; synchronous, active-high.
- `flick` — input, 1 — start / kickback request; level-sampled.
- `lamps` — output, 16 — lamp vector; `lamps[i] = (i < level)`; registered.
- `level` — output, 5 — current lit-lamp count, 0..16.
- `state` — output, 3 — current state code, for debug.
- `busy` — output, 1 — high whenever `state` is not IDLE.
- `done` — output, 1 — one-cycle pulse on return to IDLE at the end of a pattern.

## Operation
The states are listed below. In each case, `level` moves by 1 per tick toward the stated bound, and the target state is entered on the same edge the bound is reached.
- IDLE (0): `level` = 0. `flick` = 1 on any clock edge moves to UP16.
- UP16 (1): count up from 0 to 16, then go to DN5.
- DN5 (2): count down from 16 to 5.
  - `flick` = 1 on that tick: go to UP16 (kickback).
  - Otherwise: go to UP10.
- UP10 (3): count up from 5 to 10, then go to DN0.
- DN0 (4): count down from 10 to 0.
  - Reaching 5 with `flick` = 1: go to UP10 (kickback); otherwise keep counting down.
  - Reaching 0 with `flick` = 1: go to UP10.
  - Reaching 0 with `flick` = 0: go to UP5.
- UP5 (5): count up from 0 to 5, then go to DNEND.
- DNEND (6): count down from 5 to 0, then go to IDLE and pulse `done`.
- Illegal codes (7): go to IDLE with `level` = 0 on the next edge.

Flick sampling rules:
- `flick` is evaluated only in IDLE and at the kickback points (DN5 reaching 5; DN0 reaching 5 or 0).
- At all other times `flick` is ignored. No request is latched.

Level rules:
- `level` is 5 bits, saturating-free by construction: it never leaves 0..16.
- An assertion fires if `level` would wrap.

## Timing
- Reset values: `state` = IDLE, `level` = 0, `lamps` = 16'h0000, `busy` = 0, `done` = 0, prescaler = 0.
- Reset mid-pattern forces all reset values on the next edge.

Prescaler and ticks:
- The prescaler is held at 0 in IDLE.
- Outside IDLE it counts 0..TICK_DIV-1. A tick is asserted when the count equals TICK_DIV-1, and the count then wraps to 0.
- With TICK_DIV = 1, every cycle outside IDLE is a tick.

Start latency:
- `flick` = 1 at edge N in IDLE gives `state` = UP16 and `busy` = 1 after edge N, with `level` still 0.
- The first increment occurs TICK_DIV cycles later.

Output timing:
- `lamps` and `level` update on the same edge; there is no extra pipeline stage.
- `done` is high for exactly the one cycle after the edge on which DNEND reaches 0.

Pattern length:
- A pattern with no kickbacks is 52 ticks (16 + 11 + 5 + 10 + 5 + 5).
- The pattern occupies 52 × TICK_DIV cycles from the first cycle in UP16 to the `done` pulse.

## Structure
- Package `bf_pkg` holds:
  - the `state_t` enum with the codes above;
  - `LAMP_N`;
  - the bound constants: `LVL_MAX` = 16, `LVL_MID` = 10, `LVL_KICK` = 5, `LVL_MIN` = 0.
- Sub-module `bf_tick_prescaler` (inputs `clk`, `rst`, `run`; output `tick`; parameter `TICK_DIV`) generates the step strobe.
- The state machine, the `level` counter and the thermometer lamp decode are in the top module.

## Test plan
- Reset, then `flick` pulse, TICK_DIV = 1, no further `flick`:
  - `level` trace is 0→16→5→10→0→5→0;
  - `done` pulses after 52 ticks;
  - `lamps` = 16'hFFFF at the peak, 16'h001F at `level` 5.
- `flick` held high at the DN5 tick reaching 5: state returns to UP16, and `level` climbs 5→16.
- `flick` high at the DN0 tick reaching 5: state goes to UP10. `flick` high when DN0 reaches 0: UP10 from 0 to 10.
- `flick` toggling during UP16 and UP5: no effect on the trace.
- `rst` asserted at `level` 9 in UP10: after the next edge, all outputs equal their reset values; a new `flick` restarts from 0.
- TICK_DIV = 4:
  - first increment occurs 4 cycles after entering UP16;
  - `level` changes exactly every 4 cycles;
  - total pattern length is 208 cycles.
